// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory port.
// The address check is also used by the core's M stage.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 32;
  localparam int unsigned DMEM_LANES = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        write;
  } dmem_rsp_t;

  // Widened compare so a large DEPTH cannot wrap the byte limit.
  function automatic logic dmem_addr_err(
    input logic [31:0] addr,
    input int unsigned depth
  );
    logic [33:0] lim;
    lim = 34'(depth) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= lim);
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Small in-order buffer of responses waiting for the initiator.
// Storage is not reset; only the pointers and count are.
module dmem_rsp_fifo
  import dmem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  dmem_rsp_t push_data,
  input  logic      pop,
  output dmem_rsp_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  dmem_rsp_t     mem_q [N];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt_q == CW'(N));
  assign empty    = (cnt_q == '0);
  assign pop_data = mem_q[rd_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      wr_d = (wr_q == PW'(N - 1)) ? '0 : wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == PW'(N - 1)) ? '0 : rd_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane word array, fixed latency,
// in-order responses with an address error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = 1,
  parameter int MAX_OUT = LATENCY + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_write
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [31:0]   mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx;
  logic          acc_err;
  logic          accept;
  logic          pop;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  dmem_rsp_t     ent;
  dmem_rsp_t     push_data;
  dmem_rsp_t     head;

  assign idx     = req_addr[AW+1:2];
  assign acc_err = dmem_addr_err(req_addr, DEPTH);

  assign req_ready = !reset
                  && (cnt_q < CW'(MAX_OUT))
                  && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Load data is captured before this edge's store lands.
  always_comb begin
    ent       = '0;
    ent.write = req_we;
    ent.err   = acc_err;
    if (!req_we && !acc_err) begin
      ent.rdata = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int i = 0; i < DMEM_LANES; i++) begin
        if (req_be[i]) begin
          mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push      = accept;
      assign push_data = ent;
    end else begin : g_pipe
      logic [LATENCY-2:0] vld_q, vld_d;
      dmem_rsp_t          dat_q [LATENCY-1];
      dmem_rsp_t          dat_d [LATENCY-1];

      always_comb begin
        vld_d[0] = accept;
        dat_d[0] = ent;
        for (int i = 1; i < LATENCY - 1; i++) begin
          vld_d[i] = vld_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY - 1; i++) begin
            dat_q[i] <= '0;
          end
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < LATENCY - 1; i++) begin
            dat_q[i] <= dat_d[i];
          end
        end
      end

      assign push      = vld_q[LATENCY-2];
      assign push_data = dat_q[LATENCY-2];
    end
  endgenerate

  dmem_rsp_fifo #(
    .N (MAX_OUT)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_err   = rsp_valid && head.err;
  assign rsp_write = rsp_valid && head.write;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder (DEPTH=32, LATENCY=1)
// against a queue-and-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_write;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_write (rsp_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        write;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          n_pops = 0;
  logic [31:0] m [32];
  exp_t        expq [$];
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        last_write = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: every accepted request yields one response,
  // in order, visible the cycle after acceptance.
  always @(negedge clk) begin
    exp_t e;
    logic er;
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", 32'(rsp_err), 0);
      chk("rst_write", 32'(rsp_write), 0);
      expq.delete();
    end else begin
      chk("req_ready", 32'(req_ready), 32'(expq.size() < 2));
      chk("rsp_valid", 32'(rsp_valid), 32'(expq.size() != 0));
      if (rsp_valid && expq.size() != 0) begin
        chk("rsp_rdata", rsp_rdata, expq[0].rdata);
        chk("rsp_err", 32'(rsp_err), 32'(expq[0].err));
        chk("rsp_write", 32'(rsp_write), 32'(expq[0].write));
        if (rsp_ready) begin
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          last_write = rsp_write;
          n_pops++;
          void'(expq.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        er = (req_addr[1:0] != 2'b00) || (req_addr >= 32'd128);
        e.err   = er;
        e.write = req_we;
        e.rdata = (!er && !req_we) ? m[req_addr[6:2]] : 32'h0;
        if (!er && req_we) begin
          for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
              m[req_addr[6:2]][8*b +: 8] = req_wdata[8*b +: 8];
            end
          end
        end
        expq.push_back(e);
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    bit done;
    done = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) chk("req_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    bit acc;
    int r;
    reset     = 1'b1;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 1);

    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      do_req(1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 4'hF);
    end
    drain();

    do_req(1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
    drain();
    chk("st_write", 32'(last_write), 1);
    chk("st_rdata", last_rdata, 0);
    do_req(1'b0, 32'h08, 32'h0, 4'h0);
    drain();
    chk("ld_word", last_rdata, 32'hDEADBEEF);

    do_req(1'b1, 32'h08, 32'h11223344, 4'b0101);
    do_req(1'b0, 32'h08, 32'h0, 4'hF);
    drain();
    chk("ld_lanes", last_rdata, 32'hDE22BE44);

    do_req(1'b0, 32'h06, 32'h0, 4'hF);
    drain();
    chk("mis_err", 32'(last_err), 1);
    chk("mis_rdata", last_rdata, 0);
    do_req(1'b1, 32'h80, 32'hFFFFFFFF, 4'hF);
    drain();
    chk("oor_err", 32'(last_err), 1);
    chk("oor_write", 32'(last_write), 1);
    do_req(1'b0, 32'h7C, 32'h0, 4'hF);
    drain();
    chk("oor_nowrite", last_rdata, 32'hC0DE001F);

    rsp_ready = 1'b0;
    do_req(1'b0, 32'h00, 32'h0, 4'hF);
    do_req(1'b0, 32'h04, 32'h0, 4'hF);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h08;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    p0 = n_pops;
    do_req(1'b0, 32'h08, 32'h0, 4'hF);
    do_req(1'b0, 32'h0C, 32'h0, 4'hF);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_throughput", 32'(n_pops - p0), 4);
    chk("bp_last", last_rdata, 32'hC0DE0003);
    drain();

    do_req(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
    drain();
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'hF);
    do_req(1'b0, 32'h14, 32'h0, 4'hF);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    p0 = n_pops;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_silent", 32'(n_pops - p0), 0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF);
    drain();
    chk("mid_rst_kept", last_rdata, 32'hA5A5A5A5);

    acc = 1'b0;
    for (int it = 0; it < 600; it++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid = 1'b1;
          req_we    = $urandom_range(0, 1) == 1;
          req_wdata = $urandom;
          req_be    = 4'($urandom_range(0, 15));
          r = $urandom_range(0, 9);
          if (r == 0) begin
            req_addr = 32'($urandom_range(0, 127)) | 32'h1;
          end else if (r == 1) begin
            req_addr = ($urandom | 32'h80) & 32'hFFFFFFFC;
          end else begin
            req_addr = 32'($urandom_range(0, 31)) << 2;
          end
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the core's M-stage load/store initiator over a valid/ready request channel and a valid/ready response channel.
- Word-addressed storage array with byte-lane writes, a fixed configurable latency, in-order responses, and an error flag for misaligned or out-of-range accesses.
- Replaces the core's internal RAM array once the memory port is split out of the pipeline.

Parameters:
DEPTH, 32, number of 32-bit words; power of two, at least 2
LATENCY, 1, cycles from the accepting edge to response valid; range 1..4
MAX_OUT, LATENCY+1, maximum accepted-but-unpopped requests; also the response buffer depth

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables; bit i enables lane [8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  initiator accepts the response
rsp_rdata  out  32  load data; 0 for stores and errors
rsp_err  out  1  access was misaligned or out of range
rsp_write  out  1  response acknowledges a store

Behaviour:
- Reset is asynchronous and active-high. While reset is high: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_write=0; the outstanding count and all in-flight or buffered responses are cleared. Array contents are not reset.
- Accept condition: req_valid & req_ready at a rising edge. Each accepted request produces exactly one response. Responses are returned strictly in acceptance order.
- req_ready = !reset & (outstanding < MAX_OUT).
  - outstanding is a registered count: incremented on accept, decremented on response pop (rsp_valid & rsp_ready).
  - Accept and pop in the same cycle leave the count unchanged.
- Word index = req_addr[log2(DEPTH)+1:2].
- Error condition: req_addr[1:0] != 0, or req_addr >= 4*DEPTH. An erroring access never modifies the array and responds with rsp_err=1, rsp_rdata=0.
- Store (no error):
  - Lanes with req_be set are written at the accepting edge.
  - req_be=0 is a legal no-op that is still acknowledged.
  - Response fields: rsp_write=1, rsp_rdata=0, rsp_err=0.
- Load (no error):
  - Full word is sampled at the accepting edge; req_be is ignored.
  - Response fields: rsp_write=0, rsp_err=0.
  - Ordering: the load reads the array state before any store accepted on the same edge. A store accepted at an earlier edge is always visible.
- Latency: a request accepted at edge k has its response visible (rsp_valid=1) from edge k+LATENCY-1 onward, provided no older response is still pending.
  - LATENCY=1 means rsp_valid is high in the cycle immediately after the accepting edge.
  - Response fields are held stable while rsp_valid & !rsp_ready.
- Throughput: with rsp_ready held at 1, one request is accepted every cycle indefinitely at any LATENCY.
- Backpressure: with rsp_ready=0, exactly MAX_OUT requests are accepted, then req_ready=0 until a pop. The buffer never overflows or drops a response.
- Reset mid-operation: all in-flight and buffered responses are discarded and none are emitted after release. Stores accepted before reset assertion remain committed.
- req_ready rises in the first cycle after reset deasserts.

Decomposition:
- Package dmem_pkg holds:
  - DEPTH default.
  - Response struct {rdata[31:0], err, write}.
  - Byte-lane count constant (4).
  - Alignment/range check function shared with the core's M stage.
- Sub-module dmem_rsp_fifo:
  - Parameterised MAX_OUT-deep synchronous FIFO of response structs.
  - push/pop/full/empty; async active-high reset clears the pointers.
  - The LATENCY delay line feeds its push port.

Test Plan:
- Reset: hold reset 3 cycles with req_valid=1 -> req_ready=0 and rsp_valid=0 throughout; req_ready=1 in the first cycle after release.
- Store/load: store 0xDEADBEEF to 0x08 with be=4'hF, then load 0x08 -> two responses in order: {write=1, err=0, rdata=0}, then {rdata=0xDEADBEEF, err=0}.
- Byte lanes: after the previous step, store 0x11223344 to 0x08 with be=4'b0101, then load 0x08 -> rdata=0xDE22BE44.
- Errors: load 0x06 -> err=1, rdata=0. Store 0xFFFFFFFF to 0x80 (DEPTH=32) -> err=1, write=1. A following load of 0x7C returns its prior value unchanged.
- Backpressure and throughput (LATENCY=1): with rsp_ready=0, drive 4 back-to-back loads of 0x00/0x04/0x08/0x0C -> exactly 2 accepted, then req_ready=0. Raise rsp_ready -> responses arrive in address order and the remaining 2 are accepted, sustaining one response per cycle.
- Reset mid-flight: store 0xA5A5A5A5 to 0x10, then 2 loads outstanding with rsp_ready=0; assert reset -> rsp_valid falls immediately and no responses follow release. A load of 0x10 afterwards returns 0xA5A5A5A5.
